// File: rtl/spi_pkg.sv
// spi_frame_rx shared types and frame layout.
// Frame is rw | addr | data, MSB first on the wire.
package spi_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int SR_W       = 1 + ADDR_W + DATA_W;
  localparam int CNT_W      = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/spi_frame_rx_if.sv
// Decoded-frame bundle toward the register-file write port.
// master drives, slave consumes.
interface spi_frame_rx_if;
  import spi_pkg::*;

  logic              txn_valid;
  logic              txn_rw;
  logic [ADDR_W-1:0] txn_addr;
  logic [DATA_W-1:0] txn_data;
  logic              frame_err;

  modport master (
    output txn_valid,
    output txn_rw,
    output txn_addr,
    output txn_data,
    output frame_err
  );

  modport slave (
    input txn_valid,
    input txn_rw,
    input txn_addr,
    input txn_data,
    input frame_err
  );

endinterface

// File: rtl/spi_sync.sv
// Flop-chain synchronizer for one asynchronous input.
// RST_VAL is the idle level loaded while in reset.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= {STAGES{RST_VAL}};
    else        ff <= STAGES'({ff, d});
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_frame_rx.sv
// SPI mode-0 frame receiver, SCLK oversampled in the clk domain.
// Emits one decoded write/read transaction per well-formed frame.
module spi_frame_rx
  import spi_pkg::*;
#(
  parameter int FRAME_BITS  = spi_pkg::FRAME_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic COPI,
  input  logic nCS,
  input  logic SCLK,
  spi_frame_rx_if.master txn
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);

  logic copi_s, ncs_s, sclk_s;
  logic ncs_d, sclk_d;
  logic ncs_fall, ncs_rise, sclk_rise;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_copi (
    .clk(clk), .rst_n(rst_n), .d(COPI), .q(copi_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs (
    .clk(clk), .rst_n(rst_n), .d(nCS), .q(ncs_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .d(SCLK), .q(sclk_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ncs_d  <= 1'b1;
      sclk_d <= 1'b0;
    end else begin
      ncs_d  <= ncs_s;
      sclk_d <= sclk_s;
    end
  end

  assign ncs_fall  = ~ncs_s & ncs_d;
  assign ncs_rise  = ncs_s & ~ncs_d;
  assign sclk_rise = sclk_s & ~sclk_d;

  // A fall seen before the chain holds real pin values would be the
  // reset level draining out; only accept one after nCS was truly high.
  logic [SYNC_STAGES:0] settle;
  logic                 armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle <= '0;
      armed  <= 1'b0;
    end else begin
      settle <= {settle[SYNC_STAGES-1:0], 1'b1};
      armed  <= armed | (settle[SYNC_STAGES] & ncs_s & ncs_d);
    end
  end

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [SR_W-1:0]  sr, sr_n;
  logic             valid_n, err_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sr    <= sr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sr_n    = sr;
    valid_n = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (ncs_fall && armed) begin
          state_n = ACTIVE;
          cnt_n   = '0;
          sr_n    = '0;
        end
      end
      ACTIVE: begin
        if (ncs_rise) begin
          state_n = IDLE;
          if (cnt == CNT_FULL) valid_n = 1'b1;
          else                 err_n   = 1'b1;
        end else if (sclk_rise) begin
          sr_n = {sr[SR_W-2:0], copi_s};
          if (cnt != CNT_MAX) cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn.txn_valid <= 1'b0;
      txn.frame_err <= 1'b0;
      txn.txn_rw    <= 1'b0;
      txn.txn_addr  <= '0;
      txn.txn_data  <= '0;
    end else begin
      txn.txn_valid <= valid_n;
      txn.frame_err <= err_n;
      if (valid_n) begin
        txn.txn_rw   <= sr[SR_W-1];
        txn.txn_addr <= sr[DATA_W +: ADDR_W];
        txn.txn_data <= sr[DATA_W-1:0];
      end
    end
  end

endmodule
